// File: rtl/load_store_queue_pkg.sv
// ============================================================================
// Module : load_store_queue_pkg
// Shared widths, type-field layout, size codes and queue entry for the LSQ.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package load_store_queue_pkg;
  localparam int LS_TYPE_BIT          = 4;
  localparam int ROB_WIDTH_BIT        = 4;
  localparam int DEF_LSB_SIZE_BIT     = 2;
  localparam int LS_STORE             = 3;
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [31:0] DEF_IO_ADDR_BASE = 32'h0003_0000;

  typedef struct packed {
    logic                     valid;
    logic [LS_TYPE_BIT-1:0]   ty;
    logic [31:0]              r1;
    logic [31:0]              r2;
    logic [ROB_WIDTH_BIT-1:0] dep1;
    logic [ROB_WIDTH_BIT-1:0] dep2;
    logic                     has1;
    logic                     has2;
    logic [11:0]              off;
    logic [ROB_WIDTH_BIT-1:0] rob;
  } lsq_entry_t;

  function automatic logic [31:0] calc_addr(input logic [31:0] base, input logic [11:0] off);
    return base + {{20{off[11]}}, off};
  endfunction
endpackage

`default_nettype wire

// File: rtl/load_store_queue_wb_match.sv
// ============================================================================
// Module : lsq_wb_match
// Matches one pending tag against all writeback channels plus the LSQ's own
// result; the lowest channel index wins, own result has lowest priority.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsq_wb_match
  import load_store_queue_pkg::*;
#(
  parameter int NUM_WB = 2
) (
  input  logic [ROB_WIDTH_BIT-1:0]        tag,
  input  logic [NUM_WB-1:0]               wb_valid,
  input  logic [NUM_WB*ROB_WIDTH_BIT-1:0] wb_rob_id,
  input  logic [NUM_WB*32-1:0]            wb_value,
  input  logic                            own_valid,
  input  logic [ROB_WIDTH_BIT-1:0]        own_rob_id,
  input  logic [31:0]                     own_value,
  output logic                            hit,
  output logic [31:0]                     value
);
  always_comb begin
    hit   = own_valid && (own_rob_id == tag);
    value = own_value;
    // Walk from the highest channel down so lower indices overwrite.
    for (int c = NUM_WB - 1; c >= 0; c--) begin
      if (wb_valid[c] && (wb_rob_id[c*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] == tag)) begin
        hit   = 1'b1;
        value = wb_value[c*32 +: 32];
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/load_store_queue.sv
// ============================================================================
// Module : load_store_queue
// In-order load/store FIFO with writeback snooping, mispredict flush with
// orphan drain, MMIO load ordering and a registered cache request port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int          LSB_SIZE_BIT = DEF_LSB_SIZE_BIT,
  parameter int          NUM_WB       = 2,
  parameter logic [31:0] IO_ADDR_BASE = DEF_IO_ADDR_BASE
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            flush,
  input  logic                            inst_valid,
  input  logic [LS_TYPE_BIT-1:0]          inst_type,
  input  logic [31:0]                     inst_r1,
  input  logic [31:0]                     inst_r2,
  input  logic [ROB_WIDTH_BIT-1:0]        inst_dep1,
  input  logic [ROB_WIDTH_BIT-1:0]        inst_dep2,
  input  logic                            inst_has_dep1,
  input  logic                            inst_has_dep2,
  input  logic [11:0]                     inst_offset,
  input  logic [ROB_WIDTH_BIT-1:0]        inst_rob_id,
  output logic                            full,
  input  logic [ROB_WIDTH_BIT-1:0]        rob_id_head,
  input  logic [NUM_WB-1:0]               wb_valid,
  input  logic [NUM_WB*ROB_WIDTH_BIT-1:0] wb_rob_id,
  input  logic [NUM_WB*32-1:0]            wb_value,
  output logic                            cache_valid,
  output logic                            cache_wr,
  output logic [2:0]                      cache_size,
  output logic [31:0]                     cache_addr,
  output logic [31:0]                     cache_value,
  input  logic                            cache_ready,
  input  logic [31:0]                     cache_res,
  output logic                            lsb_ready,
  output logic [ROB_WIDTH_BIT-1:0]        lsb_rob_id,
  output logic [31:0]                     lsb_value
);
  localparam int DEPTH = 1 << LSB_SIZE_BIT;
  localparam logic [LSB_SIZE_BIT:0]   FULL_CNT = (LSB_SIZE_BIT+1)'(DEPTH);
  localparam logic [LSB_SIZE_BIT:0]   CNT_ONE  = (LSB_SIZE_BIT+1)'(1);
  localparam logic [LSB_SIZE_BIT-1:0] PTR_ONE  = LSB_SIZE_BIT'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_ORPHAN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [LSB_SIZE_BIT-1:0] head_q, head_d, tail_q, tail_d;
  logic [LSB_SIZE_BIT:0]   count_q, count_d;
  lsq_entry_t              ent_q [DEPTH];
  lsq_entry_t              ent_d [DEPTH];
  logic                    req_wr_q, req_wr_d;
  logic [2:0]              req_size_q, req_size_d;
  logic [31:0]             req_addr_q, req_addr_d;
  logic [31:0]             req_value_q, req_value_d;

  lsq_entry_t  head_ent;
  logic [31:0] head_addr;
  logic        issue, pop, push;
  logic        push1_hit, push2_hit;
  logic [31:0] push1_val, push2_val;
  logic [DEPTH-1:0] snp1_hit, snp2_hit;
  logic [31:0] snp1_val [DEPTH];
  logic [31:0] snp2_val [DEPTH];

  assign head_ent  = ent_q[head_q];
  assign head_addr = calc_addr(head_ent.r1, head_ent.off);
  assign pop       = rdy_in && (state_q == ST_BUSY) && cache_ready;
  assign push      = rdy_in && !flush && inst_valid && (count_q != FULL_CNT);
  // Loads below the MMIO window go speculatively; stores and MMIO loads wait for commit.
  assign issue     = rdy_in && !flush && (state_q == ST_IDLE) && head_ent.valid
                     && !head_ent.has1 && !head_ent.has2
                     && ((!head_ent.ty[LS_STORE] && (head_addr < IO_ADDR_BASE))
                         || (head_ent.rob == rob_id_head));

  assign lsb_ready   = pop;
  assign lsb_rob_id  = pop ? head_ent.rob : '0;
  assign lsb_value   = pop ? cache_res : '0;
  assign full        = (count_q == FULL_CNT) || ((count_q == FULL_CNT - CNT_ONE) && inst_valid && !pop);
  assign cache_valid = (state_q != ST_IDLE);
  assign cache_wr    = req_wr_q;
  assign cache_size  = req_size_q;
  assign cache_addr  = req_addr_q;
  assign cache_value = req_value_q;

  lsq_wb_match #(.NUM_WB(NUM_WB)) u_push1 (
    .tag(inst_dep1), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .own_valid(lsb_ready), .own_rob_id(lsb_rob_id), .own_value(lsb_value),
    .hit(push1_hit), .value(push1_val)
  );
  lsq_wb_match #(.NUM_WB(NUM_WB)) u_push2 (
    .tag(inst_dep2), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .own_valid(lsb_ready), .own_rob_id(lsb_rob_id), .own_value(lsb_value),
    .hit(push2_hit), .value(push2_val)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    lsq_wb_match #(.NUM_WB(NUM_WB)) u_snp1 (
      .tag(ent_q[i].dep1), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
      .own_valid(lsb_ready), .own_rob_id(lsb_rob_id), .own_value(lsb_value),
      .hit(snp1_hit[i]), .value(snp1_val[i])
    );
    lsq_wb_match #(.NUM_WB(NUM_WB)) u_snp2 (
      .tag(ent_q[i].dep2), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
      .own_valid(lsb_ready), .own_rob_id(lsb_rob_id), .own_value(lsb_value),
      .hit(snp2_hit[i]), .value(snp2_val[i])
    );
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].has1 && snp1_hit[i]) begin
        ent_d[i].r1   = snp1_val[i];
        ent_d[i].has1 = 1'b0;
      end
      if (ent_q[i].valid && ent_q[i].has2 && snp2_hit[i]) begin
        ent_d[i].r2   = snp2_val[i];
        ent_d[i].has2 = 1'b0;
      end
    end
    if (pop) ent_d[head_q].valid = 1'b0;
    if (push) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].ty    = inst_type;
      ent_d[tail_q].r1    = (inst_has_dep1 && push1_hit) ? push1_val : inst_r1;
      ent_d[tail_q].r2    = (inst_has_dep2 && push2_hit) ? push2_val : inst_r2;
      ent_d[tail_q].dep1  = inst_dep1;
      ent_d[tail_q].dep2  = inst_dep2;
      ent_d[tail_q].has1  = inst_has_dep1 && !push1_hit;
      ent_d[tail_q].has2  = inst_has_dep2 && !push2_hit;
      ent_d[tail_q].off   = inst_offset;
      ent_d[tail_q].rob   = inst_rob_id;
    end

    head_d  = pop  ? head_q + PTR_ONE : head_q;
    tail_d  = push ? tail_q + PTR_ONE : tail_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      tail_d  = head_d;
      count_d = '0;
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (issue) state_d = ST_BUSY;
      ST_BUSY:   if (cache_ready) state_d = ST_IDLE;
                 else if (flush) state_d = ST_ORPHAN;
      ST_ORPHAN: if (cache_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    req_wr_d    = req_wr_q;
    req_size_d  = req_size_q;
    req_addr_d  = req_addr_q;
    req_value_d = req_value_q;
    if (issue) begin
      req_wr_d    = head_ent.ty[LS_STORE];
      req_size_d  = head_ent.ty[2:0];
      req_addr_d  = head_addr;
      req_value_d = head_ent.r2;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      req_wr_q    <= 1'b0;
      req_size_q  <= '0;
      req_addr_q  <= '0;
      req_value_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      req_wr_q    <= req_wr_d;
      req_size_q  <= req_size_d;
      req_addr_q  <= req_addr_d;
      req_value_q <= req_value_d;
    end
  end
endmodule

`default_nettype wire
